// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-7 (x^7+x^6+1) checker: slices signed samples to bits,
// locks a local predictor onto the stream and keeps saturating bit/error counts.
module prbs_checker #(
    parameter int SIG_WIDTH   = 16,
    parameter int LOCK_COUNT  = 32,
    parameter int UNLOCK_ERRS = 8,
    parameter int WINDOW      = 128,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic signed [SIG_WIDTH-1:0] sig,
    input  logic                        clr_cnt,
    output logic                        locked,
    output logic                        err,
    output logic [CNT_WIDTH-1:0]        bit_count,
    output logic [CNT_WIDTH-1:0]        err_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [MW-1:0] LOCK_LAST = MW'(LOCK_COUNT - 1);
    localparam logic [EW-1:0] ERR_LAST  = EW'(UNLOCK_ERRS - 1);
    localparam logic [WW-1:0] WIN_LAST  = WW'(WINDOW - 1);
    localparam logic signed [SIG_WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_q;
    logic [6:0]           r_q;
    logic [2:0]           seed_cnt_q;
    logic [MW-1:0]        match_cnt_q;
    logic [WW-1:0]        win_cnt_q;
    logic [EW-1:0]        win_errs_q;
    logic                 locked_q;
    logic                 err_q;
    logic [CNT_WIDTH-1:0] bit_cnt_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    logic       bit_d;
    logic       pred_d;
    logic       mism_d;
    logic [6:0] r_rx_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Zero slices to 1, so the sign test is "not negative".
    assign bit_d  = (sig >= ZERO);
    assign pred_d = r_q[6] ^ r_q[5];
    assign mism_d = bit_d ^ pred_d;
    assign r_rx_d = {r_q[5:0], bit_d};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEED;
            r_q         <= '0;
            seed_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_errs_q  <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (en) begin
                case (state_q)
                    SEED: begin
                        r_q <= r_rx_d;
                        if (seed_cnt_q == 3'd6) begin
                            seed_cnt_q <= '0;
                            // An all-zero history is the LFSR lock-up state; keep seeding.
                            if (r_rx_d != 7'd0) begin
                                state_q     <= TRACK;
                                match_cnt_q <= '0;
                            end
                        end else begin
                            seed_cnt_q <= seed_cnt_q + 3'd1;
                        end
                    end
                    TRACK: begin
                        r_q <= r_rx_d;
                        if (!mism_d) begin
                            if (match_cnt_q == LOCK_LAST) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                win_cnt_q  <= '0;
                                win_errs_q <= '0;
                            end else begin
                                match_cnt_q <= match_cnt_q + 1'b1;
                            end
                        end else begin
                            state_q    <= SEED;
                            seed_cnt_q <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so a bad bit cannot corrupt the history.
                        r_q <= {r_q[5:0], pred_d};
                        err_q <= mism_d;
                        if (mism_d && (win_errs_q == ERR_LAST)) begin
                            state_q    <= SEED;
                            locked_q   <= 1'b0;
                            seed_cnt_q <= '0;
                        end else if (win_cnt_q == WIN_LAST) begin
                            win_cnt_q  <= '0;
                            win_errs_q <= '0;
                        end else begin
                            win_cnt_q <= win_cnt_q + 1'b1;
                            if (mism_d) begin
                                win_errs_q <= win_errs_q + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q    <= SEED;
                        locked_q   <= 1'b0;
                        seed_cnt_q <= '0;
                    end
                endcase

                if (clr_cnt) begin
                    bit_cnt_q <= '0;
                    err_cnt_q <= '0;
                end else if (state_q == LOCKED) begin
                    bit_cnt_q <= sat_inc(bit_cnt_q);
                    if (mism_d) begin
                        err_cnt_q <= sat_inc(err_cnt_q);
                    end
                end
            end
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule
